// File: rtl/ternary_dot_accum.sv
// Streaming ternary dot-product accumulator: 5-lane add/subtract/skip partial sum,
// saturating accumulation over BEATS weight groups, valid/ready result port.
module ternary_dot_accum #(
    parameter int ACT_W = 8,
    parameter int ACC_W = 24,
    parameter int BEATS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [9:0]         weights,
    input  logic [5*ACT_W-1:0] acts,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_sat
);
    localparam int P_W   = ACT_W + 3;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    // Codes 01 add, 11 subtract; 00 and the illegal 10 contribute nothing.
    function automatic logic [P_W-1:0] lane_sum(input logic [9:0] w, input logic [5*ACT_W-1:0] a);
        logic [P_W-1:0] s;
        logic [P_W-1:0] x;
        s = '0;
        for (int i = 0; i < 5; i++) begin
            x = {{3{a[ACT_W*i+ACT_W-1]}}, a[ACT_W*i +: ACT_W]};
            case (w[2*i +: 2])
                2'b01:   s = s + x;
                2'b11:   s = s - x;
                default: s = s;
            endcase
        end
        return s;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P_W-1:0]   p_sum_q, p_sum_d;
    logic             p_valid_q, p_valid_d;
    logic             p_last_q, p_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_acc_q, sat_acc_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_sat_q, out_sat_d;
    logic             hold_s, accept_s, drain_s, clamp_s;
    logic [ACC_W:0]   wide_s;
    logic [ACC_W-1:0] sum_s;

    // A finished result waiting on a stalled output freezes stage P.
    assign hold_s    = p_valid_q && p_last_q && out_valid_q && !out_ready;
    assign in_ready  = !hold_s;
    assign accept_s  = in_valid && !hold_s;
    assign drain_s   = p_valid_q && !hold_s;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        wide_s  = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-P_W){p_sum_q[P_W-1]}}, p_sum_q};
        clamp_s = (wide_s[ACC_W] != wide_s[ACC_W-1]);
        if (!clamp_s) begin
            sum_s = wide_s[ACC_W-1:0];
        end else if (wide_s[ACC_W]) begin
            sum_s = ACC_MIN;
        end else begin
            sum_s = ACC_MAX;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        p_sum_d     = p_sum_q;
        p_valid_d   = p_valid_q;
        p_last_d    = p_last_q;
        acc_d       = acc_q;
        sat_acc_d   = sat_acc_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        if (accept_s) begin
            p_sum_d   = lane_sum(weights, acts);
            p_valid_d = 1'b1;
            p_last_d  = (cnt_q == CNT_LAST);
            cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end else if (!hold_s) begin
            p_valid_d = 1'b0;
        end else begin
            p_valid_d = p_valid_q;
        end
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        // A last partial landing on an accepting edge replaces the result with no bubble.
        if (drain_s) begin
            if (p_last_q) begin
                out_sum_d   = sum_s;
                out_sat_d   = sat_acc_q | clamp_s;
                out_valid_d = 1'b1;
                acc_d       = '0;
                sat_acc_d   = 1'b0;
            end else begin
                acc_d     = sum_s;
                sat_acc_d = sat_acc_q | clamp_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            p_sum_q     <= '0;
            p_valid_q   <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= '0;
            sat_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            p_sum_q     <= p_sum_d;
            p_valid_q   <= p_valid_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            sat_acc_q   <= sat_acc_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_ternary_dot_accum.sv
// Bench for ternary_dot_accum: three configurations share one stimulus stream and are
// checked against a vector-level reference model plus hand-computed directed results.
module tb_ternary_dot_accum;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [9:0]  weights = '0;
    logic [39:0] acts = '0;
    logic [2:0]  rdy_v, ov_v, sat_v;
    logic [23:0] sum_a, sum_c;
    logic [11:0] sum_b;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ternary_dot_accum #(.ACT_W(8), .ACC_W(24), .BEATS(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[0]), .weights(weights),
        .acts(acts), .out_valid(ov_v[0]), .out_ready(out_ready), .out_sum(sum_a), .out_sat(sat_v[0]));
    ternary_dot_accum #(.ACT_W(8), .ACC_W(12), .BEATS(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[1]), .weights(weights),
        .acts(acts), .out_valid(ov_v[1]), .out_ready(out_ready), .out_sum(sum_b), .out_sat(sat_v[1]));
    ternary_dot_accum #(.ACT_W(8), .ACC_W(24), .BEATS(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_v[2]), .weights(weights),
        .acts(acts), .out_valid(ov_v[2]), .out_ready(out_ready), .out_sum(sum_c), .out_sat(sat_v[2]));

    int     beats_m[3] = '{4, 4, 1};
    int     accw_m[3]  = '{24, 12, 24};
    longint vacc[3];
    bit     vsat[3];
    int     vcnt[3];
    longint qs[3][64];
    bit     qt[3][64];
    int     wr[3];
    int     rd[3];
    bit     ph[3];
    longint ps[3];
    bit     pt[3];
    longint s_m, c_m;

    task automatic chk(input string nm, input int k, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, k, act, exp);
        end
    endtask

    function automatic logic signed [63:0] get_sum(input int k);
        case (k)
            0:       return 64'($signed(sum_a));
            1:       return 64'($signed(sum_b));
            default: return 64'($signed(sum_c));
        endcase
    endfunction

    function automatic longint partial(input logic [9:0] w, input logic [39:0] a);
        longint s;
        longint v;
        s = 0;
        for (int i = 0; i < 5; i++) begin
            v = longint'($signed(a[8*i +: 8]));
            if (w[2*i +: 2] == 2'b01) s = s + v;
            else if (w[2*i +: 2] == 2'b11) s = s - v;
        end
        return s;
    endfunction

    function automatic longint clampv(input longint x, input int aw);
        longint mx;
        mx = (longint'(1) << (aw - 1)) - 1;
        if (x > mx) return mx;
        if (x < -mx - 1) return -mx - 1;
        return x;
    endfunction

    // Reference model and scoreboard, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                vacc[k] = 0; vsat[k] = 0; vcnt[k] = 0; rd[k] = wr[k]; ph[k] = 0;
                chk("rst_out_valid", k, ov_v[k], 0);
                chk("rst_out_sum", k, get_sum(k), 0);
                chk("rst_out_sat", k, sat_v[k], 0);
                chk("rst_in_ready", k, rdy_v[k], 1);
            end else begin
                if (ph[k]) begin
                    chk("hold_valid", k, ov_v[k], 1);
                    chk("hold_sum", k, get_sum(k), ps[k]);
                    chk("hold_sat", k, sat_v[k], pt[k]);
                end
                if (ov_v[k] && out_ready) begin
                    chk("result_expected", k, (wr[k] - rd[k] > 0) ? 1 : 0, 1);
                    if (wr[k] - rd[k] > 0) begin
                        chk("sum", k, get_sum(k), qs[k][rd[k] % 64]);
                        chk("sat", k, sat_v[k], qt[k][rd[k] % 64]);
                        rd[k]++;
                    end
                end
                ph[k] = ov_v[k] && !out_ready;
                ps[k] = get_sum(k);
                pt[k] = sat_v[k];
                if (in_valid && rdy_v[k]) begin
                    s_m = vacc[k] + partial(weights, acts);
                    c_m = clampv(s_m, accw_m[k]);
                    if (c_m != s_m) vsat[k] = 1;
                    vacc[k] = c_m;
                    vcnt[k]++;
                    if (vcnt[k] == beats_m[k]) begin
                        qs[k][wr[k] % 64] = vacc[k];
                        qt[k][wr[k] % 64] = vsat[k];
                        wr[k]++;
                        vacc[k] = 0; vsat[k] = 0; vcnt[k] = 0;
                    end
                end
            end
        end
    end

    task automatic run_vec(input logic [9:0] w, input logic [39:0] a, input int n);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; weights = w; acts = a;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_vec(input string nm, input int k, input longint es, input bit et);
        @(negedge clk);
        chk({nm, "_early"}, k, ov_v[k], 0);
        @(negedge clk);
        chk({nm, "_valid"}, k, ov_v[k], 1);
        chk({nm, "_sum"}, k, get_sum(k), es);
        chk({nm, "_sat"}, k, sat_v[k], et);
        @(negedge clk);
        chk({nm, "_one_cycle"}, k, ov_v[k], 0);
    endtask

    initial begin
        chk("model_mixed", 0, partial(10'b1110010001, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}), -10);
        chk("model_clamp", 0, clampv(2540, 12), 2047);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_vec(10'b0101010101, {5{8'd1}}, 4);
        check_vec("all_plus1", 0, 20, 0);
        run_vec(10'b1111111111, {5{8'd127}}, 4);
        check_vec("all_minus1", 0, -2540, 0);
        run_vec(10'b1110010001, {8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 4);
        check_vec("mixed", 0, -40, 0);
        run_vec(10'b0101010101, {5{8'd127}}, 4);
        check_vec("saturate", 1, 2047, 1);
        run_vec(10'b0101010101, {5{8'd1}}, 4);
        check_vec("sat_cleared", 1, 20, 0);

        // Backpressure on the single-beat configuration.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; weights = 10'b0000000001; acts = {5{8'd5}};
        @(posedge clk); #1;
        acts = {5{8'd7}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_first_sum", 2, get_sum(2), 5);
        chk("bp_in_ready_low", 2, rdy_v[2], 0);
        @(negedge clk);
        chk("bp_still_sum", 2, get_sum(2), 5);
        chk("bp_still_low", 2, rdy_v[2], 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_before_accept", 2, get_sum(2), 5);
        @(negedge clk);
        chk("bp_second_valid", 2, ov_v[2], 1);
        chk("bp_second_sum", 2, get_sum(2), 7);
        chk("bp_in_ready_back", 2, rdy_v[2], 1);
        @(negedge clk);
        chk("bp_drained", 2, ov_v[2], 0);

        repeat (400) begin
            @(posedge clk); #1;
            in_valid   = ($urandom_range(0, 3) != 0);
            weights    = 10'($urandom);
            acts[31:0] = $urandom;
            acts[39:32] = 8'($urandom);
            out_ready  = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("nothing_lost", k, wr[k] - rd[k], 0);

        run_vec(10'b0101010101, {5{8'd1}}, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 0, ov_v[0], 0);
        chk("midrst_sum", 0, get_sum(0), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_vec(10'b0101010101, {5{8'd1}}, 4);
        check_vec("after_reset", 0, 20, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("final_drain", k, wr[k] - rd[k], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
